// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: Z80-facing VDP data (0xBE) / control (0xBF) port.
// Decodes CPU strobes into VRAM writes, CRAM writes, register writes and
// read-buffer prefetches. Owns the VRAM port-B address/write lines.
// Optional feature macro: VDP_GG_CRAM_LATCH_EN (Game Gear 12-bit CRAM via
// even/odd byte latch). Undefined builds the SMS 6-bit CRAM path.
module vdp_cpu_port #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned CRAM_ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_we,
  input  logic                   cpu_rd,
  input  logic                   cpu_port,
  input  logic [7:0]             cpu_din,
  output logic [7:0]             cpu_dout,
  output logic                   busy,
  output logic [ADDR_W-1:0]      vram_addr,
  output logic                   vram_we,
  output logic [7:0]             vram_wdata,
  input  logic [7:0]             vram_rdata,
  output logic [CRAM_ADDR_W-1:0] cram_addr,
  output logic                   cram_we,
  output logic [11:0]            cram_wdata,
  output logic                   reg_we,
  output logic [3:0]             reg_addr,
  output logic [7:0]             reg_data,
  input  logic [7:0]             status_in,
  output logic                   status_rd
);

  localparam int unsigned HI_W = ADDR_W - 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [1:0]             code_q, code_d;
  logic                   second_byte_q, second_byte_d;
  logic [7:0]             latch_q, latch_d;
  logic [7:0]             read_buf_q, read_buf_d;
`ifdef VDP_GG_CRAM_LATCH_EN
  logic [7:0]             cram_latch_q, cram_latch_d;
`endif

  logic [7:0]             cpu_dout_q, cpu_dout_d;
  logic                   busy_q, busy_d;
  logic [ADDR_W-1:0]      vram_addr_q, vram_addr_d;
  logic                   vram_we_q, vram_we_d;
  logic [7:0]             vram_wdata_q, vram_wdata_d;
  logic [CRAM_ADDR_W-1:0] cram_addr_q, cram_addr_d;
  logic                   cram_we_q, cram_we_d;
  logic [11:0]            cram_wdata_q, cram_wdata_d;
  logic                   reg_we_q, reg_we_d;
  logic [3:0]             reg_addr_q, reg_addr_d;
  logic [7:0]             reg_data_q, reg_data_d;
  logic                   status_rd_q, status_rd_d;

  logic                   idle;
  logic                   ctrl_wr, data_wr, ctrl_rd, data_rd;
  logic                   start_pf;
  logic [ADDR_W-1:0]      addr_inc;

  // Strobe qualification: write wins over read, everything dropped while busy
  always_comb begin
    idle     = (state_q == ST_IDLE);
    ctrl_wr  = idle & cpu_we & cpu_port;
    data_wr  = idle & cpu_we & ~cpu_port;
    ctrl_rd  = idle & ~cpu_we & cpu_rd & cpu_port;
    data_rd  = idle & ~cpu_we & cpu_rd & ~cpu_port;
    start_pf = data_rd | (ctrl_wr & second_byte_q & (cpu_din[7:6] == 2'd0));
    addr_inc = addr_q + ADDR_W'(1);
  end

  // Prefetch FSM next-state: one cycle to issue the address, one for RAM latency
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_pf) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; pulses default low, everything else holds
  always_comb begin
    addr_d        = addr_q;
    code_d        = code_q;
    second_byte_d = second_byte_q;
    latch_d       = latch_q;
    read_buf_d    = read_buf_q;
`ifdef VDP_GG_CRAM_LATCH_EN
    cram_latch_d  = cram_latch_q;
`endif
    cpu_dout_d    = cpu_dout_q;
    vram_addr_d   = vram_addr_q;
    vram_we_d     = 1'b0;
    vram_wdata_d  = vram_wdata_q;
    cram_addr_d   = cram_addr_q;
    cram_we_d     = 1'b0;
    cram_wdata_d  = cram_wdata_q;
    reg_we_d      = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_data_d    = reg_data_q;
    status_rd_d   = 1'b0;

    if (ctrl_wr) begin
      if (!second_byte_q) begin
        latch_d       = cpu_din;
        addr_d[7:0]   = cpu_din;
        second_byte_d = 1'b1;
      end else begin
        code_d               = cpu_din[7:6];
        addr_d[ADDR_W-1:8]   = HI_W'(cpu_din[5:0]);
        second_byte_d        = 1'b0;
        if (cpu_din[7:6] == 2'd2) begin
          reg_we_d   = 1'b1;
          reg_addr_d = cpu_din[3:0];
          reg_data_d = latch_q;
        end
      end
    end else if (data_wr) begin
      second_byte_d = 1'b0;
      addr_d        = addr_inc;
      if (code_q != 2'd3) begin
        vram_we_d    = 1'b1;
        vram_addr_d  = addr_q;
        vram_wdata_d = cpu_din;
        read_buf_d   = cpu_din;
      end else begin
`ifdef VDP_GG_CRAM_LATCH_EN
        // Even byte is parked; odd byte commits the full 12-bit entry
        if (!addr_q[0]) begin
          cram_latch_d = cpu_din;
        end else begin
          cram_we_d    = 1'b1;
          cram_addr_d  = CRAM_ADDR_W'({addr_q[5:1], 1'b0});
          cram_wdata_d = {cpu_din[3:0], cram_latch_q};
        end
`else
        cram_we_d    = 1'b1;
        cram_addr_d  = CRAM_ADDR_W'({addr_q[4:0], 1'b0});
        cram_wdata_d = {6'b0, cpu_din[5:0]};
`endif
      end
    end else if (data_rd) begin
      second_byte_d = 1'b0;
      cpu_dout_d    = read_buf_q;
    end else if (ctrl_rd) begin
      second_byte_d = 1'b0;
      cpu_dout_d    = status_in;
      status_rd_d   = 1'b1;
    end

    // Prefetch uses the address as updated by the triggering access
    if (idle && (state_d == ST_FETCH)) begin
      vram_addr_d = addr_d;
    end

    if (state_q == ST_CAPTURE) begin
      read_buf_d = vram_rdata;
      addr_d     = addr_inc;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      code_q        <= '0;
      second_byte_q <= 1'b0;
      latch_q       <= '0;
      read_buf_q    <= '0;
`ifdef VDP_GG_CRAM_LATCH_EN
      cram_latch_q  <= '0;
`endif
      cpu_dout_q    <= '0;
      busy_q        <= 1'b0;
      vram_addr_q   <= '0;
      vram_we_q     <= 1'b0;
      vram_wdata_q  <= '0;
      cram_addr_q   <= '0;
      cram_we_q     <= 1'b0;
      cram_wdata_q  <= '0;
      reg_we_q      <= 1'b0;
      reg_addr_q    <= '0;
      reg_data_q    <= '0;
      status_rd_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      code_q        <= code_d;
      second_byte_q <= second_byte_d;
      latch_q       <= latch_d;
      read_buf_q    <= read_buf_d;
`ifdef VDP_GG_CRAM_LATCH_EN
      cram_latch_q  <= cram_latch_d;
`endif
      cpu_dout_q    <= cpu_dout_d;
      busy_q        <= busy_d;
      vram_addr_q   <= vram_addr_d;
      vram_we_q     <= vram_we_d;
      vram_wdata_q  <= vram_wdata_d;
      cram_addr_q   <= cram_addr_d;
      cram_we_q     <= cram_we_d;
      cram_wdata_q  <= cram_wdata_d;
      reg_we_q      <= reg_we_d;
      reg_addr_q    <= reg_addr_d;
      reg_data_q    <= reg_data_d;
      status_rd_q   <= status_rd_d;
    end
  end

  assign cpu_dout   = cpu_dout_q;
  assign busy       = busy_q;
  assign vram_addr  = vram_addr_q;
  assign vram_we    = vram_we_q;
  assign vram_wdata = vram_wdata_q;
  assign cram_addr  = cram_addr_q;
  assign cram_we    = cram_we_q;
  assign cram_wdata = cram_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_addr   = reg_addr_q;
  assign reg_data   = reg_data_q;
  assign status_rd  = status_rd_q;

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- CPU-side VDP port: decodes Z80 writes and reads on the data port (0xBE) and control port (0xBF).
- Produces the VRAM write traffic (name table, pattern data) that the background and sprite renderers read back.
- Also produces CRAM writes, VDP register writes, and read-buffer prefetches.
- Sits between the Z80 bus decoder and the dual-port VRAM/CRAM; owns the VRAM write port.

Parameters:
- ADDR_W, 14, VRAM address width (16 KB).
- CRAM_ADDR_W, 6, CRAM byte-address width (64 bytes).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_we  in  1  one-cycle write strobe
- cpu_rd  in  1  one-cycle read strobe
- cpu_port  in  1  0 = data port, 1 = control port
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data, registered
- busy  out  1  high during a prefetch; strobes ignored while high
- vram_addr  out  14  VRAM port-B address
- vram_we  out  1  VRAM write enable
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM port-B data, valid one cycle after vram_addr
- cram_addr  out  6  CRAM byte address
- cram_we  out  1  CRAM write enable
- cram_wdata  out  12  CRAM entry (GG 4:4:4)
- reg_we  out  1  register write pulse
- reg_addr  out  4  register index
- reg_data  out  8  register value
- status_in  in  8  status byte from VDP core
- status_rd  out  1  pulse: status was read (core clears its flags)

Behaviour:
- Reset values (async on rst): addr=0, code=0, second_byte=0, latch=0, read_buf=0, cram_latch=0, state=IDLE; all outputs 0.
- All outputs are registered. Write-side effects appear on the cycle after the strobe.
- addr is 14 bits and wraps 0x3FFF -> 0x0000 on increment.
- Control write, second_byte=0: latch<=din; addr[7:0]<=din; second_byte<=1.
- Control write, second_byte=1: code<=din[7:6]; addr[13:8]<=din[5:0]; second_byte<=0. Then by code:
  - code 0: enter prefetch.
  - code 1 or 3: no further action.
  - code 2: reg_we=1, reg_addr=din[3:0], reg_data=latch, for one cycle.
- Data write, code != 3:
  - vram_we=1, vram_addr=addr, vram_wdata=din for one cycle.
  - read_buf<=din; addr++.
- Data write, code == 3: CRAM path (see Optional Feature); addr++.
- Data read:
  - cpu_dout<=read_buf; enter prefetch.
  - cpu_dout holds until the next read.
- Control read: cpu_dout<=status_in; status_rd=1 for one cycle.
- Any data-port access or control read clears second_byte.
- Prefetch FSM:
  - IDLE -> FETCH: drive vram_addr=addr, vram_we=0, busy=1.
  - FETCH -> CAPTURE: wait for RAM latency.
  - CAPTURE -> IDLE: read_buf<=vram_rdata; addr++; busy=0.
  - Prefetch takes 3 cycles from strobe to busy falling.
- Strobes while busy=1 are dropped. The Z80 access spacing guarantees this never occurs in-system.
- cpu_we and cpu_rd asserted together: cpu_we wins, cpu_rd is ignored.
- rst mid-prefetch: return to IDLE; read_buf=0; busy=0.

Optional Feature:
- Macro: VDP_GG_CRAM_LATCH_EN.
- Defined (Game Gear):
  - Even addr: cram_latch<=din, no cram_we.
  - Odd addr: cram_we=1, cram_addr={addr[5:1],1'b0}, cram_wdata={din[3:0],cram_latch}.
- Undefined (SMS):
  - Every CRAM data write: cram_we=1, cram_addr={addr[4:0],1'b0}, cram_wdata={6'b0,din[5:0]}.
  - cram_latch is unused.

Test Plan:
- Control 0x00 then 0x40; data writes 0xAA, 0xBB -> vram_we pulses at 0x0000=0xAA and 0x0001=0xBB; addr=0x0002.
- Control 0x12 then 0x81 -> one reg_we pulse: reg_addr=1, reg_data=0x12; no VRAM write.
- Preload VRAM 0x3800=0x55, 0x3801=0x66; control 0x00, 0x38 (code 0); data read twice -> cpu_dout=0x55 then 0x66; busy high 3 cycles after each.
- Address wrap: set write addr 0x3FFF; two data writes -> writes land at 0x3FFF then 0x0000.
- Control 0x34 (first byte only); control read -> cpu_dout=status_in, status_rd pulse; next control write 0x56 is treated as a first byte (addr[7:0]=0x56).
- VDP_GG_CRAM_LATCH_EN defined; control 0x02, 0xC0; data 0x0F, 0x0A -> single cram_we: cram_addr=2, cram_wdata=0xA0F. Without the macro -> two cram_we: addr 4 data 0x0F, addr 6 data 0x0A.
